// File: rtl/ppu_pkg.sv
// ppu_pkg: shared widths, beat type and sink FSM states for the CPU-to-VRAM write path
package ppu_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 64;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0]   addr;
        logic [VRAM_DATA_W-1:0]   data;
        logic [VRAM_DATA_W/8-1:0] byteena;
    } vram_wr_beat_t;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        DONE
    } sink_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of VRAM write beats; head entry is always visible on dout
module sync_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  vram_wr_beat_t din,
    input  logic          pop,
    output vram_wr_beat_t dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    vram_wr_beat_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rptr];

    // storage array needs no reset; only the pointers define validity
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= din;

    // pointers wrap modulo DEPTH; count tracks occupancy including the full state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end

endmodule

// File: rtl/h2f_vram_sink.sv
// h2f_vram_sink: buffers CPU VRAM writes and commits them only during vblank
module h2f_vram_sink
    import ppu_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int BUSY_MARGIN = 4,
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   h2f_vram_wraddr,
    input  logic                h2f_vram_wren,
    input  logic [DATA_W-1:0]   h2f_vram_wrdata,
    input  logic [DATA_W/8-1:0] h2f_vram_byteena,
    input  logic                vblank_start,
    input  logic                vblank_end,
    output logic [ADDR_W-1:0]   vram_wraddr,
    output logic                vram_wren,
    output logic [DATA_W-1:0]   vram_wrdata,
    output logic [DATA_W/8-1:0] vram_byteena,
    output logic                cpu_wr_busy,
    output logic                cpu_vram_wr_irq,
    output logic                overflow,
    input  logic                overflow_clr
);

    localparam int CW = $clog2(DEPTH) + 1;

    sink_state_e   state;
    vram_wr_beat_t beat_in;
    vram_wr_beat_t beat_out;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    assign beat_in    = '{addr: h2f_vram_wraddr, data: h2f_vram_wrdata, byteena: h2f_vram_byteena};
    assign push       = h2f_vram_wren && !full;
    assign pop        = state == DRAIN && !vblank_end && !empty;
    assign count_next = count + CW'(push) - CW'(pop);

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (beat_in),
        .pop   (pop),
        .dout  (beat_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // vblank window FSM; irq fires on the cycle the last queued beat is popped
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= ACTIVE;
            cpu_vram_wr_irq <= 1'b0;
        end else begin
            cpu_vram_wr_irq <= 1'b0;
            case (state)
                ACTIVE: if (vblank_start && !vblank_end) state <= DRAIN;
                DRAIN:
                    if (vblank_end) state <= ACTIVE;
                    else if (count_next == '0) begin
                        state           <= DONE;
                        cpu_vram_wr_irq <= 1'b1;
                    end
                DONE:   if (vblank_end) state <= ACTIVE;
                default: state <= ACTIVE;
            endcase
        end

    // commit port: strobe follows each pop, address/data/byteena hold between commits
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vram_wren    <= 1'b0;
            vram_wraddr  <= '0;
            vram_wrdata  <= '0;
            vram_byteena <= '0;
        end else begin
            vram_wren <= pop;
            if (pop) begin
                vram_wraddr  <= beat_out.addr;
                vram_wrdata  <= beat_out.data;
                vram_byteena <= beat_out.byteena;
            end
        end

    // backpressure looks ahead at next-cycle occupancy so the CPU sees it in time
    always_ff @(posedge clk or posedge rst)
        if (rst) cpu_wr_busy <= 1'b0;
        else cpu_wr_busy <= (CW'(DEPTH) - count_next) <= CW'(BUSY_MARGIN);

    // sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else if (h2f_vram_wren && full) overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;

endmodule

// File: tb/tb_h2f_vram_sink.sv
// tb_h2f_vram_sink: scoreboard bench for the vblank-gated VRAM write sink
module tb_h2f_vram_sink;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] h2f_vram_wraddr = '0;
    logic        h2f_vram_wren = 1'b0;
    logic [63:0] h2f_vram_wrdata = '0;
    logic [7:0]  h2f_vram_byteena = '0;
    logic        vblank_start = 1'b0;
    logic        vblank_end = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [12:0] vram_wraddr;
    logic        vram_wren;
    logic [63:0] vram_wrdata;
    logic [7:0]  vram_byteena;
    logic        cpu_wr_busy;
    logic        cpu_vram_wr_irq;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int irq_cnt = 0;
    int w0;
    int i0;
    vram_wr_beat_t exp_q[$];
    vram_wr_beat_t mon_e;
    logic [15:0] wr_hist;
    logic [15:0] irq_hist;

    h2f_vram_sink dut (
        .clk              (clk),
        .rst              (rst),
        .h2f_vram_wraddr  (h2f_vram_wraddr),
        .h2f_vram_wren    (h2f_vram_wren),
        .h2f_vram_wrdata  (h2f_vram_wrdata),
        .h2f_vram_byteena (h2f_vram_byteena),
        .vblank_start     (vblank_start),
        .vblank_end       (vblank_end),
        .vram_wraddr      (vram_wraddr),
        .vram_wren        (vram_wren),
        .vram_wrdata      (vram_wrdata),
        .vram_byteena     (vram_byteena),
        .cpu_wr_busy      (cpu_wr_busy),
        .cpu_vram_wr_irq  (cpu_vram_wr_irq),
        .overflow         (overflow),
        .overflow_clr     (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic s, input logic e);
        vblank_start = s;
        vblank_end   = e;
        tick();
        vblank_start = 1'b0;
        vblank_end   = 1'b0;
    endtask

    task automatic push_beat(input logic [12:0] a, input logic [63:0] d, input logic [7:0] b, input bit acc);
        h2f_vram_wraddr  = a;
        h2f_vram_wrdata  = d;
        h2f_vram_byteena = b;
        h2f_vram_wren    = 1'b1;
        if (acc) exp_q.push_back('{addr: a, data: d, byteena: b});
        tick();
        h2f_vram_wren = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [12:0] base);
        for (int i = 0; i < n; i++)
            push_beat(base + 13'(i), {32'(i) ^ 32'hC0DE0000, 32'(base) + 32'(i * 3)}, 8'(i * 7 + 1), 1'b1);
    endtask

    task automatic record(input int n);
        wr_hist  = '0;
        irq_hist = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            wr_hist[k]  = vram_wren;
            irq_hist[k] = cpu_vram_wr_irq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = cpu_vram_wr_irq;
        end
        @(posedge clk);
        #1;
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wren"}, 64'(vram_wren), 64'd0);
        chk({tag, "_addr"}, 64'(vram_wraddr), 64'd0);
        chk({tag, "_data"}, vram_wrdata, 64'd0);
        chk({tag, "_be"}, 64'(vram_byteena), 64'd0);
        chk({tag, "_busy"}, 64'(cpu_wr_busy), 64'd0);
        chk({tag, "_irq"}, 64'(cpu_vram_wr_irq), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (cpu_vram_wr_irq) irq_cnt++;
                    if (vram_wren) begin
                        wr_cnt++;
                        if (exp_q.size() == 0) chk("spurious_wr", 64'(vram_wren), 64'd0);
                        else begin
                            mon_e = exp_q.pop_front();
                            chk("wr_addr", 64'(vram_wraddr), 64'(mon_e.addr));
                            chk("wr_data", vram_wrdata, mon_e.data);
                            chk("wr_be", 64'(vram_byteena), 64'(mon_e.byteena));
                        end
                    end
                end
            end
        join_none

        idle(3);
        chk_zero("rst");
        rst = 1'b0;
        idle(2);

        push_beat(13'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1);
        push_beat(13'h011, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1);
        push_beat(13'h012, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1'b1);
        idle(3);
        chk("basic_no_early_wr", 64'(wr_cnt), 64'd0);
        pulse(1'b1, 1'b0);
        record(8);
        chk("basic_wr_timing", 64'(wr_hist), 64'h001C);
        chk("basic_irq_timing", 64'(irq_hist), 64'h0010);
        pulse(1'b0, 1'b1);

        push_n(59, 13'h100);
        chk("busy_at_59", 64'(cpu_wr_busy), 64'd0);
        push_beat(13'h1F0, 64'h6060_6060_0000_0060, 8'h60, 1'b1);
        chk("busy_at_60", 64'(cpu_wr_busy), 64'd1);
        push_n(4, 13'h1F1);
        chk("ovf_at_64", 64'(overflow), 64'd0);
        overflow_clr = 1'b1;
        push_beat(13'h1FF, 64'hDEAD_DEAD_DEAD_DEAD, 8'h0F, 1'b0);
        overflow_clr = 1'b0;
        chk("ovf_set_beats_clr", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);
        w0 = wr_cnt;
        pulse(1'b1, 1'b0);
        wait_irq("full_irq");
        chk("full_wr_count", 64'(wr_cnt - w0), 64'd64);
        chk("full_busy_low", 64'(cpu_wr_busy), 64'd0);
        pulse(1'b0, 1'b1);

        push_n(40, 13'h400);
        w0 = wr_cnt;
        i0 = irq_cnt;
        pulse(1'b1, 1'b0);
        idle(19);
        pulse(1'b0, 1'b1);
        idle(3);
        chk("partial_wr_count", 64'(wr_cnt - w0), 64'd19);
        chk("partial_no_irq", 64'(irq_cnt - i0), 64'd0);
        chk("partial_kept", 64'(exp_q.size()), 64'd21);
        pulse(1'b1, 1'b0);
        wait_irq("partial_irq");
        chk("partial_total", 64'(wr_cnt - w0), 64'd40);
        pulse(1'b0, 1'b1);

        pulse(1'b1, 1'b0);
        record(6);
        chk("empty_no_wr", 64'(wr_hist), 64'd0);
        chk("empty_irq_timing", 64'(irq_hist), 64'h0004);
        pulse(1'b0, 1'b1);

        push_n(5, 13'h800);
        w0 = wr_cnt;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_beat(13'h900 + 13'(i), {32'hFACE0000 + 32'(i), 32'(i)}, 8'(8'h80 >> (i % 8)), 1'b1);
            chk("ovl_busy", 64'(cpu_wr_busy), 64'd0);
        end
        wait_irq("ovl_irq");
        chk("ovl_wr_count", 64'(wr_cnt - w0), 64'd15);
        chk("ovl_q_empty", 64'(exp_q.size()), 64'd0);
        pulse(1'b0, 1'b1);

        push_n(2, 13'hA00);
        w0 = wr_cnt;
        pulse(1'b1, 1'b1);
        idle(5);
        chk("both_no_wr", 64'(wr_cnt - w0), 64'd0);
        pulse(1'b1, 1'b0);
        wait_irq("both_irq");
        chk("both_then_drain", 64'(wr_cnt - w0), 64'd2);
        pulse(1'b0, 1'b1);

        push_n(10, 13'hB00);
        pulse(1'b1, 1'b0);
        idle(2);
        chk("pre_rst_wren", 64'(vram_wren), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        exp_q.delete();
        tick();
        rst = 1'b0;
        idle(2);
        w0 = wr_cnt;
        pulse(1'b1, 1'b0);
        record(6);
        chk("post_rst_no_wr", 64'(wr_hist), 64'd0);
        chk("post_rst_irq", 64'(irq_hist), 64'h0004);
        chk("post_rst_cnt", 64'(wr_cnt - w0), 64'd0);
        pulse(1'b0, 1'b1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
